keycode_fifo_pio: RTL and testbench



---
 rtl/keycode_pkg.sv | 22 ++
 rtl/keycode_sync_fifo.sv | 46 ++++
 rtl/keycode_fifo_pio.sv | 83 ++++++++
 tb/tb_keycode_fifo_pio.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/keycode_pkg.sv
// keycode_pkg: register map, bit positions and width helper for the keycode PIO
package keycode_pkg;
   localparam logic [1:0] ADDR_PUSH   = 2'd0;
   localparam logic [1:0] ADDR_HELD   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;
   localparam int STAT_EMPTY    = 0;
   localparam int STAT_FULL     = 1;
   localparam int STAT_OVF      = 2;
   localparam int STAT_LEVEL_LSB = 8;
   localparam int CTRL_EN       = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_FLUSH    = 2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/keycode_sync_fifo.sv
// keycode_sync_fifo: first-word-fall-through FIFO with flush and level count
module keycode_sync_fifo
   import keycode_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      level
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_pop, do_push;

   assign empty   = level == '0;
   assign full    = level == (AW+1)'(DEPTH);
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // storage array; flush and dropped pushes leave it untouched
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;

   // pointers wrap naturally; level tracks occupancy including the full state
   always_ff @(posedge clk or posedge reset)
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push & ~do_pop) level <= level + 1'b1;
         else if (do_pop & ~do_push) level <= level - 1'b1;
      end
endmodule

// File: rtl/keycode_fifo_pio.sv
// keycode_fifo_pio: Avalon-MM PIO with held-key channels and a keypress event FIFO (optional irq: KEYCODE_FIFO_IRQ_EN)
module keycode_fifo_pio
   import keycode_pkg::*;
#(
   parameter int KEY_W = 8,
   parameter int NUM_CH = 4,
   parameter int FIFO_DEPTH = 8,
   localparam int AW = clog2(FIFO_DEPTH),
   localparam int HW = NUM_CH * KEY_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic             read,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [HW-1:0]    held_keys,
   output logic [KEY_W-1:0] key_data,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             irq
);
   logic wr, wr_push, wr_held, wr_stat, wr_ctrl;
   logic enable, irq_en, overflow, flush, pop, empty, full, ovf_set;
   logic [AW:0] level;
   logic unused_ok;

   assign unused_ok = ^{read, writedata};
   assign wr      = chipselect & ~write_n;
   assign wr_push = wr & (address == ADDR_PUSH);
   assign wr_held = wr & (address == ADDR_HELD);
   assign wr_stat = wr & (address == ADDR_STATUS);
   assign wr_ctrl = wr & (address == ADDR_CTRL);
   assign flush   = wr_ctrl & writedata[CTRL_FLUSH];
   assign key_valid = ~empty & enable;
   assign pop     = key_valid & key_ready;
   assign ovf_set = wr_push & full & ~pop & ~flush;

   keycode_sync_fifo #(.WIDTH(KEY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(wr_push), .pop(pop), .flush(flush),
      .din(writedata[KEY_W-1:0]), .dout(key_data), .empty(empty), .full(full), .level(level)
   );

   // held channels, enable and sticky overflow; a dropped push beats a same-cycle clear
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         held_keys <= '0;
         enable    <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (wr_held) held_keys <= writedata[HW-1:0];
         if (wr_ctrl) enable <= writedata[CTRL_EN];
         overflow <= ovf_set | (overflow & ~(wr_stat & writedata[STAT_OVF]));
      end

`ifdef KEYCODE_FIFO_IRQ_EN
   // interrupt enable exists only when the interrupt is built in
   always_ff @(posedge clk or posedge reset)
      if (reset) irq_en <= 1'b0;
      else if (wr_ctrl) irq_en <= writedata[CTRL_IRQ_EN];

   // registered request: refill wanted at half-empty or below, or an event was lost
   always_ff @(posedge clk or posedge reset)
      if (reset) irq <= 1'b0;
      else irq <= irq_en & (overflow | (level <= (AW+1)'(FIFO_DEPTH / 2)));
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   // zero-wait-state read mux
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_PUSH:   readdata = 32'(key_data);
         ADDR_HELD:   readdata = 32'(held_keys);
         ADDR_STATUS: readdata = {16'd0, 8'(level), 5'd0, overflow, full, empty};
         default:     readdata = {29'd0, 1'b0, irq_en, enable};
      endcase
   end
endmodule

// File: tb/tb_keycode_fifo_pio.sv
// tb_keycode_fifo_pio: directed register-table and corner-sequence bench for keycode_fifo_pio
module tb_keycode_fifo_pio;
   import keycode_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic        read = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [31:0] held_keys;
   logic [7:0]  key_data;
   logic        key_valid;
   logic        key_ready = 1'b0;
   logic        irq;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        is_wr;
      logic [1:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [14];

   keycode_fifo_pio #(.KEY_W(8), .NUM_CH(4), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read(read), .writedata(writedata), .readdata(readdata),
      .held_keys(held_keys), .key_data(key_data), .key_valid(key_valid),
      .key_ready(key_ready), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic kr);
      @(negedge clk);
      address = a;
      writedata = d;
      chipselect = 1'b1;
      write_n = 1'b0;
      key_ready = kr;
      @(negedge clk);
      chipselect = 1'b0;
      write_n = 1'b1;
      key_ready = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      chipselect = 1'b1;
      read = 1'b1;
      #1 d = readdata;
      chipselect = 1'b0;
      read = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   task automatic pop_chk(input string name, input logic [7:0] exp);
      @(negedge clk);
      check({name, "_valid"}, 32'(key_valid), 32'd1);
      check({name, "_data"}, 32'(key_data), 32'(exp));
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      vecs[0]  = '{1'b0, ADDR_STATUS, 32'h0, 32'h0000_0001};
      vecs[1]  = '{1'b0, ADDR_CTRL,   32'h0, 32'h0000_0000};
      vecs[2]  = '{1'b0, ADDR_HELD,   32'h0, 32'h0000_0000};
      vecs[3]  = '{1'b0, ADDR_PUSH,   32'h0, 32'h0000_0000};
      vecs[4]  = '{1'b1, ADDR_CTRL,   32'h1, 32'h0};
      vecs[5]  = '{1'b1, ADDR_PUSH,   32'h1A, 32'h0};
      vecs[6]  = '{1'b1, ADDR_PUSH,   32'h04, 32'h0};
      vecs[7]  = '{1'b1, ADDR_PUSH,   32'h07, 32'h0};
      vecs[8]  = '{1'b0, ADDR_STATUS, 32'h0, 32'h0000_0300};
      vecs[9]  = '{1'b0, ADDR_PUSH,   32'h0, 32'h0000_001A};
      vecs[10] = '{1'b0, ADDR_CTRL,   32'h0, 32'h0000_0001};
      vecs[11] = '{1'b1, ADDR_HELD,   32'h2C1A_0016, 32'h0};
      vecs[12] = '{1'b0, ADDR_HELD,   32'h0, 32'h2C1A_0016};
      vecs[13] = '{1'b0, ADDR_STATUS, 32'h0, 32'h0000_0300};

      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_held", held_keys, 32'h0);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_data", 32'(key_data), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data, 1'b0);
         else begin
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
         end
      end
      check("held_port", held_keys, 32'h2C1A_0016);
      check("valid_on", 32'(key_valid), 32'h1);

      pop_chk("drain0", 8'h1A);
      pop_chk("drain1", 8'h04);
      pop_chk("drain2", 8'h07);
      check("drained_valid", 32'(key_valid), 32'h0);
      rd_chk("drained_status", ADDR_STATUS, 32'h0000_0001);

      wr(ADDR_CTRL, 32'h0, 1'b0);
      for (int i = 1; i <= 9; i++) wr(ADDR_PUSH, 32'(i), 1'b0);
      rd_chk("ovf_status", ADDR_STATUS, 32'h0000_0806);
      check("paused_valid", 32'(key_valid), 32'h0);
      wr(ADDR_CTRL, 32'h1, 1'b0);
      for (int i = 1; i <= 8; i++) pop_chk($sformatf("ovf_pop%0d", i), 8'(i));
      check("ovf_empty_valid", 32'(key_valid), 32'h0);
      rd_chk("ovf_after_drain", ADDR_STATUS, 32'h0000_0005);
      wr(ADDR_STATUS, 32'h4, 1'b0);
      rd_chk("ovf_cleared", ADDR_STATUS, 32'h0000_0001);

      wr(ADDR_CTRL, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) wr(ADDR_PUSH, 32'h11 + 32'(i), 1'b0);
      rd_chk("full_status", ADDR_STATUS, 32'h0000_0802);
      wr(ADDR_CTRL, 32'h1, 1'b0);
      wr(ADDR_PUSH, 32'h55, 1'b1);
      rd_chk("pushpop_status", ADDR_STATUS, 32'h0000_0802);
      for (int i = 1; i < 8; i++) pop_chk($sformatf("pp_pop%0d", i), 8'h11 + 8'(i));
      pop_chk("pp_last", 8'h55);
      rd_chk("pp_empty", ADDR_STATUS, 32'h0000_0001);

      wr(ADDR_PUSH, 32'h21, 1'b0);
      wr(ADDR_PUSH, 32'h22, 1'b0);
      wr(ADDR_PUSH, 32'h23, 1'b0);
      wr(ADDR_CTRL, 32'h5, 1'b1);
      rd_chk("flush_status", ADDR_STATUS, 32'h0000_0001);
      check("flush_valid", 32'(key_valid), 32'h0);
      rd_chk("flush_ctrl_reads0", ADDR_CTRL, 32'h0000_0001);
      wr(ADDR_PUSH, 32'h31, 1'b0);
      pop_chk("post_flush", 8'h31);

      wr(ADDR_CTRL, 32'h0, 1'b0);
      for (int i = 0; i < 9; i++) wr(ADDR_PUSH, 32'h40 + 32'(i), 1'b0);
      wr(ADDR_CTRL, 32'h4, 1'b0);
      rd_chk("flush_keeps_ovf", ADDR_STATUS, 32'h0000_0005);
      wr(ADDR_STATUS, 32'h4, 1'b0);

      wr(ADDR_CTRL, 32'h3, 1'b0);
      repeat (2) @(negedge clk);
`ifdef KEYCODE_FIFO_IRQ_EN
      rd_chk("ctrl_irq_en", ADDR_CTRL, 32'h0000_0003);
      check("irq_low_level", 32'(irq), 32'h1);
      for (int i = 0; i < 5; i++) wr(ADDR_PUSH, 32'(i), 1'b0);
      repeat (2) @(negedge clk);
      check("irq_above_half", 32'(irq), 32'h0);
`else
      rd_chk("ctrl_irq_en_off", ADDR_CTRL, 32'h0000_0001);
      check("irq_tied", 32'(irq), 32'h0);
      for (int i = 0; i < 5; i++) wr(ADDR_PUSH, 32'(i), 1'b0);
`endif
      wr(ADDR_HELD, 32'hDEAD_BEEF, 1'b0);

      @(negedge clk);
      #2 reset = 1'b1;
      address = ADDR_STATUS;
      #1 check("async_rst_status", readdata, 32'h0000_0001);
      check("async_rst_held", held_keys, 32'h0);
      check("async_rst_valid", 32'(key_valid), 32'h0);
      check("async_rst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      rd_chk("post_rst_ctrl", ADDR_CTRL, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
